// File: rtl/mem_stage_pkg.sv
// structures: shared pipeline control structs, MEM FSM states and byte-enable constants.
package structures;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic byte_op;
    } struct_MEM;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } struct_WB;

    typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_e;

    localparam logic [7:0] BE_DWORD = 8'hFF;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store-lane replication and load-lane extraction.
// Byte access path is compiled only with MEM_BYTE_ACCESS_EN.
module dmem_lane_align
    import structures::*;
(
    input  logic        byte_op,
    input  logic [2:0]  lane,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic [7:0]  be,
    output logic [63:0] wdata,
    output logic [63:0] load_data
);

`ifdef MEM_BYTE_ACCESS_EN
    always_comb begin
        be        = byte_op ? 8'b1 << lane : BE_DWORD;
        wdata     = byte_op ? {8{store_data[7:0]}} : store_data;
        load_data = byte_op ? {56'b0, rdata[{lane, 3'b000} +: 8]} : rdata;
    end
`else
    logic unused_byte;
    assign unused_byte = ^{byte_op, lane};
    assign be          = BE_DWORD;
    assign wdata       = store_data;
    assign load_data   = rdata;
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with EX/MEM and MEM/WB registers and a stalling dmem handshake.
// Optional byte loads/stores under MEM_BYTE_ACCESS_EN.
module mem_stage
    import structures::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ALU_result,
    input  logic [63:0] ALU_B,
    input  logic [4:0]  ex_Rd,
    input  struct_MEM   ex_MEM,
    input  struct_WB    ex_WB,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] mem_ALU_result,
    output logic [4:0]  mem_Rd,
    output logic        ex_mem_reg_write,
    output logic [4:0]  wb_Rd,
    output logic        mem_wb_reg_write,
    output logic [63:0] id_write_data,
    output logic        mem_stall
);

    struct_MEM   m_mem;
    struct_WB    m_wb;
    logic [63:0] mem_B;
    mem_state_e  state, state_next;
    logic        is_mem, is_store, done, wb_mem_to_reg;
    logic [63:0] wb_alu, wb_load, load_data;

    assign is_mem   = m_mem.mem_read | m_mem.mem_write;
    assign is_store = m_mem.mem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ALU_result <= '0;
            mem_B          <= '0;
            mem_Rd         <= '0;
            m_mem          <= '0;
            m_wb           <= '0;
        end else if (!mem_stall) begin
            mem_ALU_result <= ALU_result;
            mem_B          <= ALU_B;
            mem_Rd         <= ex_Rd;
            m_mem          <= ex_MEM;
            m_wb           <= ex_WB;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A store completes on acceptance; a load completes on its response.
    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, REQ: begin
                if (is_mem) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        done       = is_store;
                        state_next = is_store ? IDLE : RESP;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_stall        = is_mem & ~done;
    assign dmem_we          = is_store;
    assign dmem_addr        = mem_ALU_result;
    assign ex_mem_reg_write = m_wb.reg_write;

    dmem_lane_align u_align (
        .byte_op    (m_mem.byte_op),
        .lane       (mem_ALU_result[2:0]),
        .store_data (mem_B),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_reg_write <= 1'b0;
            wb_Rd            <= '0;
            wb_mem_to_reg    <= 1'b0;
            wb_alu           <= '0;
            wb_load          <= '0;
        end else begin
            mem_wb_reg_write <= m_wb.reg_write & ~mem_stall;
            if (!mem_stall) begin
                wb_Rd         <= mem_Rd;
                wb_mem_to_reg <= m_wb.mem_to_reg;
                wb_alu        <= mem_ALU_result;
                wb_load       <= load_data;
            end
        end
    end

    assign id_write_data = wb_mem_to_reg ? wb_load : wb_alu;

endmodule
